// File: rtl/count_sequence_checker.sv
// count_sequence_checker: watches a free-running counter, verifies that every
// sample is the previous one plus one (mod 2^WIDTH), counts wrap-arounds once
// locked, and captures the first sequencing fault for debug.
module count_sequence_checker #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 2,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  q,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              err,
    output logic [WIDTH-1:0]  err_expected,
    output logic [WIDTH-1:0]  err_got
);

    // good_cnt only has to reach LOCK_N, so size it for that value.
    localparam int CNT_W = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        TRACK,
        ERROR
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   prev, prev_next;
    logic [CNT_W-1:0]   good_cnt, good_cnt_next;
    logic               locked_next;
    logic               wrap_pulse_next;
    logic [WRAP_W-1:0]  wrap_count_next;
    logic               err_next;
    logic [WIDTH-1:0]   err_expected_next;
    logic [WIDTH-1:0]   err_got_next;

    logic [WIDTH-1:0]   prev_inc;
    logic [CNT_W-1:0]   good_cnt_inc;
    logic               step_good;
    logic               prev_all_ones;
    logic               wrap_saturated;

    // The truncating add makes all-ones -> 0 count as a good step.
    assign prev_inc       = prev + WIDTH'(1);
    assign good_cnt_inc   = good_cnt + CNT_W'(1);
    assign step_good      = (q == prev_inc);
    assign prev_all_ones  = (prev == {WIDTH{1'b1}});
    assign wrap_saturated = (wrap_count == {WRAP_W{1'b1}});

    // Next-state and next-output logic; clr beats an en drop, which beats tracking.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next        = state;
        prev_next         = prev;
        good_cnt_next     = good_cnt;
        locked_next       = locked;
        wrap_pulse_next   = 1'b0;
        wrap_count_next   = wrap_count;
        err_next          = err;
        err_expected_next = err_expected;
        err_got_next      = err_got;

        if (clr) begin
            state_next        = IDLE;
            good_cnt_next     = '0;
            locked_next       = 1'b0;
            wrap_count_next   = '0;
            err_next          = 1'b0;
            err_expected_next = '0;
            err_got_next      = '0;
        end else if (!en && (state == SYNC || state == TRACK)) begin
            // Losing enable drops trust in q but keeps the wrap history.
            state_next  = IDLE;
            locked_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        prev_next     = q;
                        good_cnt_next = '0;
                        state_next    = SYNC;
                    end
                end
                SYNC: begin
                    prev_next = q;
                    if (step_good) begin
                        good_cnt_next = good_cnt_inc;
                        if (good_cnt_inc == CNT_W'(LOCK_N)) begin
                            state_next  = TRACK;
                            locked_next = 1'b1;
                        end
                    end else begin
                        // A glitch before lock just restarts qualification.
                        good_cnt_next = '0;
                    end
                end
                TRACK: begin
                    prev_next = q;
                    if (step_good) begin
                        if (prev_all_ones) begin
                            wrap_pulse_next = 1'b1;
                            if (!wrap_saturated) begin
                                wrap_count_next = wrap_count + WRAP_W'(1);
                            end
                        end
                    end else begin
                        state_next        = ERROR;
                        locked_next       = 1'b0;
                        err_next          = 1'b1;
                        err_expected_next = prev_inc;
                        err_got_next      = q;
                    end
                end
                ERROR: begin
                    // Frozen for debug until clr.
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev         <= '0;
            good_cnt     <= '0;
            locked       <= 1'b0;
            wrap_pulse   <= 1'b0;
            wrap_count   <= '0;
            err          <= 1'b0;
            err_expected <= '0;
            err_got      <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from pre-edge values, independent of statement order.
            state        <= state_next;
            prev         <= prev_next;
            good_cnt     <= good_cnt_next;
            locked       <= locked_next;
            wrap_pulse   <= wrap_pulse_next;
            wrap_count   <= wrap_count_next;
            err          <= err_next;
            err_expected <= err_expected_next;
            err_got      <= err_got_next;
        end
    end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Self-checking bench for count_sequence_checker: a table of hand-derived
// {inputs, expected outputs} records applied through a scoreboard queue, plus
// directed async-reset sequences. A second instance with WRAP_W=2 shares the
// stimulus to exercise wrap-count saturation.
module tb_count_sequence_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [3:0] q;

    logic       locked, wrap_pulse, err;
    logic [7:0] wrap_count;
    logic [3:0] err_expected, err_got;

    logic       locked2, wrap_pulse2, err2;
    logic [1:0] wrap_count2;
    logic [3:0] err_expected2, err_got2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       en;
        logic       clr;
        logic [3:0] q;
        logic       locked;
        logic       wp;
        logic [7:0] wc;
        logic [1:0] wc2;
        logic       err;
        logic [3:0] ee;
        logic [3:0] eg;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   reset_idx;

    count_sequence_checker #(.WIDTH(4), .LOCK_N(2), .WRAP_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr          (clr),
        .q            (q),
        .locked       (locked),
        .wrap_pulse   (wrap_pulse),
        .wrap_count   (wrap_count),
        .err          (err),
        .err_expected (err_expected),
        .err_got      (err_got)
    );

    count_sequence_checker #(.WIDTH(4), .LOCK_N(2), .WRAP_W(2)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr          (clr),
        .q            (q),
        .locked       (locked2),
        .wrap_pulse   (wrap_pulse2),
        .wrap_count   (wrap_count2),
        .err          (err2),
        .err_expected (err_expected2),
        .err_got      (err_got2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h, required %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic c, input logic [3:0] qv,
                       input logic lk, input logic wp, input logic [7:0] wc,
                       input logic [1:0] wc2, input logic er,
                       input logic [3:0] ee, input logic [3:0] eg);
        vec_t v;
        v.en = e; v.clr = c; v.q = qv; v.locked = lk; v.wp = wp;
        v.wc = wc; v.wc2 = wc2; v.err = er; v.ee = ee; v.eg = eg;
        vecs.push_back(v);
    endtask

    task automatic check_all_zero(input string tag, input int idx);
        check({tag, "_locked"}, idx, {7'd0, locked}, 8'd0);
        check({tag, "_wrap_pulse"}, idx, {7'd0, wrap_pulse}, 8'd0);
        check({tag, "_wrap_count"}, idx, wrap_count, 8'd0);
        check({tag, "_err"}, idx, {7'd0, err}, 8'd0);
        check({tag, "_err_expected"}, idx, {4'd0, err_expected}, 8'd0);
        check({tag, "_err_got"}, idx, {4'd0, err_got}, 8'd0);
        check({tag, "_sat_wrap_count"}, idx, {6'd0, wrap_count2}, 8'd0);
        check({tag, "_sat_locked"}, idx, {7'd0, locked2}, 8'd0);
    endtask

    // Mid-operation reset between edges, taken while wrap_pulse is high.
    task automatic async_reset(input int idx);
        check("pre_reset_wrap_pulse", idx, {7'd0, wrap_pulse}, 8'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst", idx);
        en  = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic build_table();
        int   wraps;
        logic [1:0] sat;
        // Lock from a counter starting at 0: locked rises at the 2nd edge after E0.
        add(1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4'd1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4'd2, 1, 0, 0, 0, 0, 0, 0);
        // Free-running while locked; wraps on each 15 -> 0, ending at q=5.
        wraps = 0;
        for (int k = 3; k <= 85; k++) begin
            logic [3:0] qv;
            qv = 4'(k % 16);
            if (qv == 4'd0) wraps++;
            sat = (wraps > 3) ? 2'd3 : 2'(wraps);
            add(1, 0, qv, 1, (qv == 4'd0), 8'(wraps), sat, 0, 0, 0);
        end
        // Fault: prev=5, q=9.
        add(1, 0, 4'd9, 0, 0, 8'd5, 2'd3, 1, 4'd6, 4'd9);
        // Frozen in ERROR against arbitrary q and en.
        for (int k = 0; k < 20; k++) begin
            add(1'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 15)),
                0, 0, 8'd5, 2'd3, 1, 4'd6, 4'd9);
        end
        // Clear with en held: everything back to 0, relock 3 edges later.
        add(1, 1, 4'($urandom_range(0, 15)), 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4'd7, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4'd8, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4'd9, 1, 0, 0, 0, 0, 0, 0);
        for (int v = 10; v <= 15; v++) add(1, 0, 4'(v), 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4'd0, 1, 1, 8'd1, 2'd1, 0, 0, 0);
        add(1, 0, 4'd1, 1, 0, 8'd1, 2'd1, 0, 0, 0);
        // Enable drop in TRACK: unlock next edge, wrap_count retained.
        add(0, 0, 4'd2, 0, 0, 8'd1, 2'd1, 0, 0, 0);
        add(0, 0, 4'd5, 0, 0, 8'd1, 2'd1, 0, 0, 0);
        // Unlocked glitch: 3,4,7,8,9 -> no error, lock only after 7,8,9.
        add(1, 0, 4'd3, 0, 0, 8'd1, 2'd1, 0, 0, 0);
        add(1, 0, 4'd4, 0, 0, 8'd1, 2'd1, 0, 0, 0);
        add(1, 0, 4'd7, 0, 0, 8'd1, 2'd1, 0, 0, 0);
        add(1, 0, 4'd8, 0, 0, 8'd1, 2'd1, 0, 0, 0);
        add(1, 0, 4'd9, 1, 0, 8'd1, 2'd1, 0, 0, 0);
        // Wrap seen while still in SYNC is not counted.
        add(0, 0, 4'd0, 0, 0, 8'd1, 2'd1, 0, 0, 0);
        add(1, 0, 4'd14, 0, 0, 8'd1, 2'd1, 0, 0, 0);
        add(1, 0, 4'd15, 0, 0, 8'd1, 2'd1, 0, 0, 0);
        add(1, 0, 4'd0, 1, 0, 8'd1, 2'd1, 0, 0, 0);
        for (int v = 1; v <= 15; v++) add(1, 0, 4'(v), 1, 0, 8'd1, 2'd1, 0, 0, 0);
        add(1, 0, 4'd0, 1, 1, 8'd2, 2'd2, 0, 0, 0);
        // After the async reset: fresh lock with no residual good_cnt.
        reset_idx = vecs.size();
        add(1, 0, 4'd5, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4'd6, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4'd7, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4'd8, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_t exp;
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        q     = 4'd0;
        build_table();

        // Reset held with enable and a moving counter: outputs stay 0.
        #2;
        check_all_zero("reset", -1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            q = 4'(k);
            @(posedge clk);
            #1;
            check_all_zero("reset_hold", -1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == reset_idx) async_reset(i);
            @(negedge clk);
            en  = vecs[i].en;
            clr = vecs[i].clr;
            q   = vecs[i].q;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check("scoreboard_empty", i, 8'd1, 8'd0);
            end else begin
                exp = sb.pop_front();
                check("locked", i, {7'd0, locked}, {7'd0, exp.locked});
                check("wrap_pulse", i, {7'd0, wrap_pulse}, {7'd0, exp.wp});
                check("wrap_count", i, wrap_count, exp.wc);
                check("sat_wrap_count", i, {6'd0, wrap_count2}, {6'd0, exp.wc2});
                check("err", i, {7'd0, err}, {7'd0, exp.err});
                check("err_expected", i, {4'd0, err_expected}, {4'd0, exp.ee});
                check("err_got", i, {4'd0, err_got}, {4'd0, exp.eg});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
